// File: rtl/al_dram_fifo_pkg.sv
// Shared defaults and status-flag type for the DRAM-backed FIFO controller.
package al_dram_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 9;
    localparam int DEFAULT_ADDR_WIDTH = 4;

    typedef struct packed {
        logic ovf;
        logic udf;
    } fifo_flags_t;

endpackage

// File: rtl/al_dram_fifo_ptr.sv
// Wrapping address pointer for one side (write or read) of the DRAM FIFO.
module al_dram_fifo_ptr
    import al_dram_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] ptr
);

    // Depth is a power of two, so natural overflow wraps DEPTH-1 -> 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/al_logic_dram_fifo_ctrl.sv
// FIFO controller driving an external async-read DRAM; define AL_DRAM_FIFO_LEVEL_EN
// to expose the occupancy count on the level port.
module al_logic_dram_fifo_ctrl
    import al_dram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int AFULL_TH   = (2 ** ADDR_WIDTH) - 2,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    output logic                  afull,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  empty,
    output logic                  aempty,
    output logic                  ovf,
    output logic                  udf,
    output logic [DATA_WIDTH-1:0] dram_di,
    output logic [ADDR_WIDTH-1:0] dram_waddr,
    output logic                  dram_we,
    output logic [ADDR_WIDTH-1:0] dram_raddr,
    input  logic [DATA_WIDTH-1:0] dram_do
`ifdef AL_DRAM_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_TH);

    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic                  push;
    logic                  pop;
    fifo_flags_t           flags;

    // Flags come from the registered count, so a location is never read and written together.
    assign full   = (count == DEPTH_C);
    assign empty  = (count == '0);
    assign afull  = (count >= AFULL_C);
    assign aempty = (count <= AEMPTY_C);

    assign push = wr_en & ~full & ~rst;
    assign pop  = rd_en & ~empty & ~rst;

    assign dram_we    = push;
    assign dram_waddr = wptr;
    assign dram_di    = wdata;
    assign dram_raddr = rptr;

    assign ovf = flags.ovf;
    assign udf = flags.udf;

`ifdef AL_DRAM_FIFO_LEVEL_EN
    assign level = count;
`endif

    al_dram_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
        .clk (clk),
        .rst (rst),
        .inc (push),
        .ptr (wptr)
    );

    al_dram_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
        .clk (clk),
        .rst (rst),
        .inc (pop),
        .ptr (rptr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + 1'b1;
        end else if (pop && !push) begin
            count <= count - 1'b1;
        end
    end

    // The DRAM read is asynchronous; capturing it here gives the one-cycle pop latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= pop;
            if (pop) begin
                rdata <= dram_do;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= '0;
        end else begin
            flags.ovf <= wr_en & full;
            flags.udf <= rd_en & empty;
        end
    end

endmodule

// File: doc/al_logic_dram_fifo_ctrl.md
AL_LOGIC_DRAM_FIFO_CTRL -- requirements
Module: al_logic_dram_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 9: FIFO word width; equals the DRAM DATA_WIDTH_W and DATA_WIDTH_R.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: DRAM address width; depth is DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2: afull asserts when count >= AFULL_TH.
REQ-004 SHALL have parameter AEMPTY_TH, default 2: aempty asserts when count <= AEMPTY_TH.
REQ-005 SHALL use one clock and a reset that is asynchronous and active-high.
REQ-006 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock; also drives the external DRAM wclk
- rst  in  1  async active-high reset
- wr_en  in  1  push request
- wdata  in  DATA_WIDTH  push data
- full  out  1  no free entry
- afull  out  1  almost full
- rd_en  in  1  pop request
- rdata  out  DATA_WIDTH  registered pop data
- rvalid  out  1  rdata valid pulse
- empty  out  1  no stored entry
- aempty  out  1  almost empty
- ovf  out  1  one-cycle pulse: push rejected because full
- udf  out  1  one-cycle pulse: pop rejected because empty
- dram_di  out  DATA_WIDTH  to DRAM di
- dram_waddr  out  ADDR_WIDTH  to DRAM waddr
- dram_we  out  1  to DRAM we
- dram_raddr  out  ADDR_WIDTH  to DRAM raddr
- dram_do  in  DATA_WIDTH  from DRAM do (asynchronous read)
- level  out  ADDR_WIDTH+1  occupancy (only with REQ-021 macro)

Function
REQ-007 SHALL accept a push when wr_en=1 and full=0; dram_we = wr_en & ~full (combinational), dram_waddr = wptr, dram_di = wdata.
REQ-008 SHALL accept a pop when rd_en=1 and empty=0; dram_raddr = rptr combinationally at all times.
REQ-009 SHALL on an accepted pop register dram_do into rdata and set rvalid=1 on the next edge; latency rd_en -> rvalid is exactly 1 cycle.
REQ-010 SHALL hold rdata unchanged and drive rvalid=0 in cycles with no accepted pop.
REQ-011 SHALL increment wptr/rptr by one per accepted push/pop, wrapping DEPTH-1 -> 0 with no gap.
REQ-012 SHALL keep count (ADDR_WIDTH+1 bits, 0..DEPTH): +1 push only, -1 pop only, unchanged for both or neither.
REQ-013 SHALL derive full=(count==DEPTH), empty=(count==0), afull, aempty from the registered count.
REQ-014 SHALL when full with wr_en=1 and rd_en=1: accept the pop, reject the push, pulse ovf; count becomes DEPTH-1.
REQ-015 SHALL when empty with wr_en=1 and rd_en=1: accept the push, reject the pop, pulse udf; count becomes 1, rvalid stays 0.
REQ-016 SHALL pulse ovf (udf) for one cycle, registered, per rejected push (pop); otherwise 0.
REQ-017 SHALL never read a location in the same cycle it is written (guaranteed by REQ-008/REQ-013).

Reset
REQ-018 SHALL on rst=1, asynchronously: wptr=0, rptr=0, count=0, empty=1, aempty=1, full=0, afull=0 (unless AFULL_TH=0), rvalid=0, rdata=0, ovf=0, udf=0.
REQ-019 SHALL force dram_we=0 while rst=1; DRAM contents are not cleared and are unreachable after reset.
REQ-020 SHALL discard in-flight pops on reset mid-operation; first accepted push after release writes address 0.

Configuration
REQ-021 SHALL with AL_DRAM_FIFO_LEVEL_EN defined expose port level = count; without it the port is absent and count stays internal.

Structure
REQ-022 SHALL take default DATA_WIDTH/ADDR_WIDTH constants and the ovf/udf flag typedef from shared package al_dram_fifo_pkg.
REQ-023 SHALL implement pointer increment/wrap in one sub-module al_dram_fifo_ptr, instantiated twice (write, read); DRAM is instantiated by the parent, not here.

Verification (DATA_WIDTH=9, ADDR_WIDTH=4, DEPTH=16, AFULL_TH=14, AEMPTY_TH=2; DRAM model attached)
REQ-024 SHALL test reset: rst pulse mid-stream -> empty=1, full=0, rvalid=0, rdata=0 asynchronously; next push writes waddr 0.
REQ-025 SHALL test fill/drain: push 0x000..0x00F -> full=1 after 16th, afull from 14th; 16 pops -> rdata 0x000..0x00F in order, each 1 cycle after rd_en; empty=1 after last.
REQ-026 SHALL test overflow/underflow: push 0x1AA when full -> ovf pulse, count 16; pop when empty -> udf pulse, rvalid=0.
REQ-027 SHALL test simultaneous: full + push/pop -> count 15, ovf=1; empty + push/pop -> count 1, udf=1, rvalid=0; count 5 + push/pop -> count 5.
REQ-028 SHALL test wrap: 40 interleaved push/pop of incrementing data -> pointers wrap 15 -> 0 twice, no data loss or reordering.
REQ-029 SHALL test AL_DRAM_FIFO_LEVEL_EN: with macro, level tracks count 0..16 through REQ-025; without it, build elaborates with no level port.
